// File: rtl/alu_decode.sv
// alu_decode: RV64I decode/issue stage producing one-hot ALU control, operands and a valid/ready handoff
module alu_decode #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   alu_sr1,
  output logic [XLEN-1:0]   alu_sr2,
  output logic [4:0]        rd,
  output logic              rd_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        mem_funct3,
  output logic [XLEN-1:0]   st_data,
  output logic              is_branch,
  output logic              is_jump,
  output logic [XLEN-1:0]   br_target,
  output logic              illegal
);
  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  logic [6:0]        w_opc, w_f7;
  logic [2:0]        w_f3, w_mf3;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_jalr_sum;
  logic [XLEN-1:0]   w_shamt_r, w_shamt_i, w_sr1, w_sr2, w_st, w_tgt;
  logic              w_op_ok, w_imm_ok, w_alt, w_shift, w_br_ok, w_accept;
  logic              w_wr, w_mrd, w_mwr, w_br, w_jmp, w_ill;
  logic [4:0]        w_alu_idx, w_br_idx, w_rd;
  logic [CTRL_W-1:0] w_alu_oh, w_br_oh, w_ctrl;
  logic              r_valid, r_rd_we, r_mrd, r_mwr, r_br, r_jmp, r_ill;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_sr1, r_sr2, r_st, r_tgt;
  logic [4:0]        r_rd;
  logic [2:0]        r_mf3;

  assign w_opc      = inst[6:0];
  assign w_f3       = inst[14:12];
  assign w_f7       = inst[31:25];
  assign w_imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign w_imm_s    = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b    = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u    = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign w_imm_j    = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_jalr_sum = rs1_data + w_imm_i;
  assign w_shamt_r  = {{(XLEN-6){1'b0}}, rs2_data[5:0]};
  assign w_shamt_i  = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign w_shift    = w_f3[1:0] == 2'b01;
  // inst[30] selects sub/sra only for register ops or immediate right shifts; addi/xori etc. ignore it
  assign w_alt      = (w_opc == OP_REG || w_f3 == 3'b101) && inst[30];
  assign w_op_ok    = w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
  assign w_imm_ok   = !w_shift || inst[31:26] == 6'd0 || (w_f3[2] && inst[31:26] == 6'b010000);
  assign w_br_ok    = w_f3[2:1] != 2'b01;
  assign w_alu_idx  = w_f3 == 3'b000 ? (w_alt ? 5'd1 : 5'd0) :
                      w_f3 == 3'b001 ? 5'd7 :
                      w_f3 == 3'b010 ? 5'd2 :
                      w_f3 == 3'b011 ? 5'd3 :
                      w_f3 == 3'b100 ? 5'd5 :
                      w_f3 == 3'b101 ? (w_alt ? 5'd9 : 5'd8) :
                      w_f3 == 3'b110 ? 5'd6 : 5'd4;
  assign w_br_idx   = w_f3[2] ? 5'd13 + {3'b0, w_f3[1:0]} : 5'd11 + {4'b0, w_f3[0]};
  assign w_alu_oh   = CTRL_W'(1) << w_alu_idx;
  assign w_br_oh    = CTRL_W'(1) << w_br_idx;
  assign w_rd       = w_wr ? inst[11:7] : 5'd0;
  assign w_accept   = in_valid & in_ready & ~flush;
  assign in_ready   = ~r_valid | out_ready;

  // Decode the incoming instruction; anything unrecognised leaves every control at zero except illegal
  always_comb begin
    w_ctrl = '0;
    w_sr1  = '0;
    w_sr2  = '0;
    w_st   = '0;
    w_tgt  = '0;
    w_mf3  = '0;
    w_wr   = 1'b0;
    w_mrd  = 1'b0;
    w_mwr  = 1'b0;
    w_br   = 1'b0;
    w_jmp  = 1'b0;
    w_ill  = 1'b0;
    case (w_opc)
      OP_REG: if (w_op_ok) begin
        w_ctrl = w_alu_oh;
        w_sr1  = rs1_data;
        w_sr2  = w_shift ? w_shamt_r : rs2_data;
        w_wr   = 1'b1;
      end else w_ill = 1'b1;
      OP_IMM: if (w_imm_ok) begin
        w_ctrl = w_alu_oh;
        w_sr1  = rs1_data;
        w_sr2  = w_shift ? w_shamt_i : w_imm_i;
        w_wr   = 1'b1;
      end else w_ill = 1'b1;
      OP_LUI: begin
        w_ctrl = CTRL_W'(1) << 10;
        w_sr2  = w_imm_u;
        w_wr   = 1'b1;
      end
      OP_AUIPC: begin
        w_ctrl = CTRL_W'(1);
        w_sr1  = pc;
        w_sr2  = w_imm_u;
        w_wr   = 1'b1;
      end
      OP_JAL: begin
        w_ctrl = CTRL_W'(1);
        w_sr1  = pc;
        w_sr2  = XLEN'(4);
        w_tgt  = pc + w_imm_j;
        w_jmp  = 1'b1;
        w_wr   = 1'b1;
      end
      OP_JALR: if (w_f3 == 3'b000) begin
        w_ctrl = CTRL_W'(1);
        w_sr1  = pc;
        w_sr2  = XLEN'(4);
        w_tgt  = {w_jalr_sum[XLEN-1:1], 1'b0};
        w_jmp  = 1'b1;
        w_wr   = 1'b1;
      end else w_ill = 1'b1;
      OP_BR: if (w_br_ok) begin
        w_ctrl = w_br_oh;
        w_sr1  = rs1_data;
        w_sr2  = rs2_data;
        w_tgt  = pc + w_imm_b;
        w_br   = 1'b1;
      end else w_ill = 1'b1;
      OP_LD: begin
        w_ctrl = CTRL_W'(1);
        w_sr1  = rs1_data;
        w_sr2  = w_imm_i;
        w_mf3  = w_f3;
        w_mrd  = 1'b1;
        w_wr   = 1'b1;
      end
      OP_ST: begin
        w_ctrl = CTRL_W'(1);
        w_sr1  = rs1_data;
        w_sr2  = w_imm_s;
        w_mf3  = w_f3;
        w_st   = rs2_data;
        w_mwr  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Output register: flush beats accept, a consumed entry with nothing behind it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_sr1   <= '0;
      r_sr2   <= '0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_mf3   <= '0;
      r_st    <= '0;
      r_br    <= 1'b0;
      r_jmp   <= 1'b0;
      r_tgt   <= '0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_sr1   <= w_sr1;
      r_sr2   <= w_sr2;
      r_rd    <= w_rd;
      r_rd_we <= w_wr & (inst[11:7] != 5'd0);
      r_mrd   <= w_mrd;
      r_mwr   <= w_mwr;
      r_mf3   <= w_mf3;
      r_st    <= w_st;
      r_br    <= w_br;
      r_jmp   <= w_jmp;
      r_tgt   <= w_tgt;
      r_ill   <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign alu_ctrl   = r_ctrl;
  assign alu_sr1    = r_sr1;
  assign alu_sr2    = r_sr2;
  assign rd         = r_rd;
  assign rd_we      = r_rd_we;
  assign mem_rd     = r_mrd;
  assign mem_wr     = r_mwr;
  assign mem_funct3 = r_mf3;
  assign st_data    = r_st;
  assign is_branch  = r_br;
  assign is_jump    = r_jmp;
  assign br_target  = r_tgt;
  assign illegal    = r_ill;
endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed scoreboard bench for the RV64I decode/issue stage
module tb_alu_decode;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data, alu_sr1, alu_sr2, st_data, br_target;
  logic [16:0] alu_ctrl;
  logic [4:0]  rd;
  logic [2:0]  mem_funct3;
  logic        rd_we, mem_rd, mem_wr, is_branch, is_jump, illegal;
  int          n_pass = 0, n_total = 0;

  typedef struct packed {
    logic [16:0] ctrl;
    logic [63:0] sr1, sr2;
    logic [4:0]  rd;
    logic        we, mrd, mwr;
    logic [2:0]  f3;
    logic [63:0] st;
    logic        br, jmp;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[$];

  alu_decode dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .alu_sr1(alu_sr1), .alu_sr2(alu_sr2), .rd(rd), .rd_we(rd_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_funct3(mem_funct3), .st_data(st_data),
    .is_branch(is_branch), .is_jump(is_jump), .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [16:0] c, input logic [63:0] a, input logic [63:0] b,
                              input logic [4:0] r);
    exp_t e = '0;
    e.ctrl = c;
    e.sr1  = a;
    e.sr2  = b;
    e.rd   = r;
    e.we   = r != 5'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".ctrl"}, 64'(alu_ctrl), 64'(e.ctrl));
    chk({tag, ".sr1"}, alu_sr1, e.sr1);
    chk({tag, ".sr2"}, alu_sr2, e.sr2);
    chk({tag, ".rd"}, 64'(rd), 64'(e.rd));
    chk({tag, ".rd_we"}, 64'(rd_we), 64'(e.we));
    chk({tag, ".mem_rd"}, 64'(mem_rd), 64'(e.mrd));
    chk({tag, ".mem_wr"}, 64'(mem_wr), 64'(e.mwr));
    chk({tag, ".f3"}, 64'(mem_funct3), 64'(e.f3));
    chk({tag, ".st"}, st_data, e.st);
    chk({tag, ".br"}, 64'(is_branch), 64'(e.br));
    chk({tag, ".jmp"}, 64'(is_jump), 64'(e.jmp));
    chk({tag, ".tgt"}, br_target, e.tgt);
    chk({tag, ".ill"}, 64'(illegal), 64'(e.ill));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                       input logic [63:0] r2);
    inst = i;
    pc = p;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
  endtask

  task automatic expect_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    if (q.size() > 0) cmp(tag, q.pop_front());
  endtask

  task automatic issue(input string tag, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r1, input logic [63:0] r2, input exp_t e);
    drive(i, p, r1, r2);
    q.push_back(e);
    tick;
    in_valid = 1'b0;
    expect_out(tag);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    inst = '0;
    pc = '0;
    rs1_data = '0;
    rs2_data = '0;
    tick;
    tick;
    chk("rst.valid", 64'(out_valid), 64'd0);
    cmp("rst", mk(17'h0, 64'h0, 64'h0, 5'd0));
    rst = 1'b0;
    tick;
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    chk("post_rst.valid", 64'(out_valid), 64'd0);

    issue("addi", 32'h00500093, 64'h0, 64'h0, 64'h7, mk(17'h00001, 64'h0, 64'h5, 5'd1));
    issue("sub", 32'h402081B3, 64'h0, 64'h9, 64'h4, mk(17'h00002, 64'h9, 64'h4, 5'd3));
    issue("slli63", 32'h03F09093, 64'h0, 64'h5, 64'h0, mk(17'h00080, 64'h5, 64'd63, 5'd1));
    issue("sll", 32'h002090B3, 64'h0, 64'h3, 64'h1C1, mk(17'h00080, 64'h3, 64'h1, 5'd1));
    e = mk(17'h00800, 64'h7, 64'h7, 5'd0);
    e.br = 1'b1;
    e.tgt = 64'h1008;
    issue("beq", 32'h00208463, 64'h1000, 64'h7, 64'h7, e);
    issue("lui", 32'h800002B7, 64'h0, 64'h55, 64'h66, mk(17'h00400, 64'h0, 64'hFFFFFFFF80000000, 5'd5));
    e = mk(17'h0, 64'h0, 64'h0, 5'd0);
    e.ill = 1'b1;
    issue("zero_inst", 32'h00000000, 64'h40, 64'h1, 64'h2, e);
    issue("auipc", 32'h00001117, 64'h2000, 64'h0, 64'h0, mk(17'h00001, 64'h2000, 64'h1000, 5'd2));
    e = mk(17'h00001, 64'h100, 64'h4, 5'd1);
    e.jmp = 1'b1;
    e.tgt = 64'h110;
    issue("jal", 32'h010000EF, 64'h100, 64'h0, 64'h0, e);
    e = mk(17'h00001, 64'h400, 64'h4, 5'd1);
    e.jmp = 1'b1;
    e.tgt = 64'h1002;
    issue("jalr", 32'h003100E7, 64'h400, 64'h1000, 64'h0, e);
    e = mk(17'h00001, 64'h100, 64'hFFFFFFFFFFFFFFF8, 5'd4);
    e.mrd = 1'b1;
    e.f3 = 3'd3;
    issue("ld", 32'hFF82B203, 64'h0, 64'h100, 64'h0, e);
    e = mk(17'h00001, 64'h200, 64'h10, 5'd0);
    e.mwr = 1'b1;
    e.f3 = 3'd3;
    e.st = 64'hDEAD;
    issue("sd", 32'h0063B823, 64'h0, 64'h200, 64'hDEAD, e);
    e = mk(17'h10000, 64'h1, 64'h2, 5'd0);
    e.br = 1'b1;
    e.tgt = 64'hFFC;
    issue("bgeu", 32'hFE20FEE3, 64'h1000, 64'h1, 64'h2, e);
    issue("srai", 32'h4050D093, 64'h0, 64'h80, 64'h0, mk(17'h00200, 64'h80, 64'h5, 5'd1));
    issue("xori_m1", 32'hFFF0C093, 64'h0, 64'h3, 64'h0, mk(17'h00020, 64'h3, 64'hFFFFFFFFFFFFFFFF, 5'd1));
    issue("add_x0", 32'h00208033, 64'h0, 64'h11, 64'h22, mk(17'h00001, 64'h11, 64'h22, 5'd0));
    e = mk(17'h0, 64'h0, 64'h0, 5'd0);
    e.ill = 1'b1;
    issue("slli_bad", 32'h40109093, 64'h0, 64'h1, 64'h1, e);
    issue("addw", 32'h002080BB, 64'h0, 64'h1, 64'h1, e);
    issue("br_010", 32'h0020A063, 64'h0, 64'h1, 64'h1, e);
    issue("mul", 32'h0220E0B3, 64'h0, 64'h1, 64'h1, e);

    tick;
    chk("drain.valid", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    drive(32'h00500093, 64'h0, 64'h0, 64'h0);
    q.push_back(mk(17'h00001, 64'h0, 64'h5, 5'd1));
    tick;
    drive(32'h402081B3, 64'h0, 64'h9, 64'h4);
    q.push_back(mk(17'h00002, 64'h9, 64'h4, 5'd3));
    for (int k = 0; k < 3; k++) begin
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      chk("hold.valid", 64'(out_valid), 64'd1);
      cmp("hold", q[0]);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    expect_out("hold_a");
    tick;
    in_valid = 1'b0;
    expect_out("hold_b");

    out_ready = 1'b0;
    drive(32'h00208463, 64'h1000, 64'h1, 64'h2);
    tick;
    in_valid = 1'b0;
    chk("flush_full.pre", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick;
    chk("flush_full.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(32'h00500093, 64'h0, 64'h0, 64'h0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in.valid", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    drive(32'h00208463, 64'h1000, 64'h1, 64'h2);
    tick;
    in_valid = 1'b0;
    chk("mid_rst.pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick;
    chk("mid_rst.valid", 64'(out_valid), 64'd0);
    cmp("mid_rst", mk(17'h0, 64'h0, 64'h0, 5'd0));
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
